adc_sample_sequencer: RTL and testbench

//  Run-time controlled ADC sample scheduler on the 125 MHz adc_clk domain.

---
 rtl/adc_sample_sequencer.sv | 98 +++++++++
 tb/tb_adc_sample_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer: divider-paced ADC capture onto a valid/ready stream, burst or continuous.
// Optional SAMPLE_SEQ_TIMESTAMP_EN adds out_ts, a free-running cycle count captured with each sample.
module adc_sample_sequencer #(
  parameter int DATA_W        = 14,
  parameter int CLK_FREQ_HZ   = 125000000,
  parameter int DEFAULT_FS_HZ = 100000,
  parameter int DIV_W         = 32,
  parameter int CNT_W         = 16
) (
  input  logic              adc_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic [DATA_W-1:0] adc_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
`ifdef SAMPLE_SEQ_TIMESTAMP_EN
  output logic [31:0]       out_ts,
`endif
  output logic              overrun
);
  localparam logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(CLK_FREQ_HZ / DEFAULT_FS_HZ);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d, div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] count_q, count_d, sample_cnt_q, sample_cnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, overrun_q, overrun_d, done_q, done_d;
  logic go, tick, hs, drop, last, fin;
  always_comb begin
    go = state_q == IDLE && start && !stop;
    tick = state_q == RUN && !stop && div_cnt_q == div_q - DIV_W'(1);
    hs = out_valid_q && out_ready;
    drop = tick && out_valid_q && !out_ready;
    last = tick && count_q != '0 && sample_cnt_q + CNT_W'(1) == count_q;
    fin = state_q == DRAIN && (!out_valid_q || hs);
    state_d = go ? RUN : (state_q == RUN && stop) ? IDLE : last ? DRAIN : fin ? IDLE : state_q;
    done_d = fin;
    div_d = go ? (cfg_div < DIV_W'(2) ? DEFAULT_DIV : cfg_div) : div_q;
    count_d = go ? cfg_count : count_q;
    div_cnt_d = go ? '0 : state_q != RUN ? div_cnt_q : tick ? '0 : div_cnt_q + DIV_W'(1);
    // count saturates; only reachable in continuous mode since bursts stop at count_q
    sample_cnt_d = go ? '0 : (tick && sample_cnt_q != '1) ? sample_cnt_q + CNT_W'(1) : sample_cnt_q;
    out_data_d = (tick && !drop) ? adc_data : out_data_q;
    out_valid_d = (tick && !drop) ? 1'b1 : hs ? 1'b0 : out_valid_q;
    overrun_d = go ? 1'b0 : drop ? 1'b1 : overrun_q;
  end
  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q <= '0;
      count_q <= '0;
      div_cnt_q <= '0;
      sample_cnt_q <= '0;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      count_q <= count_d;
      div_cnt_q <= div_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q <= overrun_d;
      done_q <= done_d;
    end
  end
`ifdef SAMPLE_SEQ_TIMESTAMP_EN
  logic [31:0] ts_q, ts_d, out_ts_q, out_ts_d;
  always_comb begin
    ts_d = ts_q + 32'd1;
    out_ts_d = (tick && !drop) ? ts_q : out_ts_q;
  end
  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) begin
      ts_q <= '0;
      out_ts_q <= '0;
    end else begin
      ts_q <= ts_d;
      out_ts_q <= out_ts_d;
    end
  end
  assign out_ts = out_ts_q;
`endif
  assign out_data = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun = overrun_q;
  assign done = done_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_adc_sample_sequencer.sv
// tb_adc_sample_sequencer: directed runs; expected samples queued at stimulus, popped by a handshake monitor.
module tb_adc_sample_sequencer;
  logic adc_clk = 0, rst = 1, start = 0, stop = 0, out_ready = 0;
  logic [31:0] cfg_div = 0;
  logic [15:0] cfg_count = 0;
  logic [13:0] adc_data, out_data;
  logic out_valid, busy, done, overrun;
  logic [31:0] cyc = 0;
  logic [13:0] exp_q[$];
  int total = 0, passes = 0;

  adc_sample_sequencer dut (
    .adc_clk(adc_clk), .rst(rst), .start(start), .stop(stop), .cfg_div(cfg_div),
    .cfg_count(cfg_count), .adc_data(adc_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .overrun(overrun)
  );

  always #4 adc_clk = ~adc_clk;
  always @(posedge adc_clk) cyc <= cyc + 1;
  assign adc_data = cyc[13:0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // a handshake completes on the next edge whenever valid&&ready holds at the falling edge
  always @(negedge adc_clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected sample: got %0h expected none", out_data);
      end else chk("sample data", out_data, exp_q.pop_front());
    end
  end

  task automatic run(input logic [31:0] div, input logic [15:0] cnt, input logic st, output int base);
    cfg_div = div;
    cfg_count = cnt;
    start = 1;
    stop = st;
    @(posedge adc_clk);
    #1;
    start = 0;
    stop = 0;
    base = cyc;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (k < 3000) begin
      @(posedge adc_clk);
      #1;
      k++;
      if (out_valid) return;
    end
  endtask

  initial begin
    int base, k, nv;
    #20;
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset overrun", overrun, 0);
    chk("reset out_data", out_data, 0);
    @(posedge adc_clk);
    #1 rst = 0;
    repeat (2) @(posedge adc_clk);
    #1;
    // burst of 3 at div 4; cfg changes mid-run must be ignored
    out_ready = 1;
    run(4, 3, 0, base);
    cfg_div = 7;
    cfg_count = 9;
    exp_q.push_back(14'(base + 3));
    exp_q.push_back(14'(base + 7));
    exp_q.push_back(14'(base + 11));
    for (int i = 1; i <= 14; i++) begin
      @(posedge adc_clk);
      #1;
      chk($sformatf("t1 valid e%0d", i), out_valid, (i == 4 || i == 8 || i == 12) ? 1 : 0);
      chk($sformatf("t1 done e%0d", i), done, i == 13 ? 1 : 0);
      chk($sformatf("t1 busy e%0d", i), busy, i < 13 ? 1 : 0);
    end
    // default divider
    run(0, 2, 0, base);
    exp_q.push_back(14'(base + 1249));
    exp_q.push_back(14'(base + 2499));
    wait_valid(k);
    chk("t2 first tick edge", k, 1250);
    wait_valid(k);
    chk("t2 tick spacing", k, 1250);
    @(posedge adc_clk);
    #1;
    chk("t2 done", done, 1);
    chk("t2 busy", busy, 0);
    // continuous, stalled consumer, then stop
    out_ready = 0;
    run(4, 0, 0, base);
    exp_q.push_back(14'(base + 3));
    for (int i = 1; i <= 16; i++) begin
      @(posedge adc_clk);
      #1;
      if (i == 4) begin
        chk("t3 first valid", out_valid, 1);
        chk("t3 first data", out_data, 14'(base + 3));
        chk("t3 no overrun yet", overrun, 0);
      end
      if (i == 8) begin
        chk("t3 overrun", overrun, 1);
        chk("t3 data held", out_data, 14'(base + 3));
        chk("t3 busy", busy, 1);
      end
      if (i == 10) stop = 1;
      if (i == 11) begin
        stop = 0;
        chk("t4 busy after stop", busy, 0);
      end
      if (i == 16) begin
        chk("t4 pending valid", out_valid, 1);
        chk("t4 pending data", out_data, 14'(base + 3));
      end
    end
    out_ready = 1;
    @(posedge adc_clk);
    #1;
    chk("t4 valid cleared", out_valid, 0);
    chk("t4 overrun sticky", overrun, 1);
    // start and stop together
    run(4, 0, 1, base);
    chk("t5 busy", busy, 0);
    nv = 0;
    repeat (8) begin
      @(posedge adc_clk);
      #1;
      if (out_valid || busy) nv++;
    end
    chk("t5 idle cycles", nv, 0);
    // async reset mid-run
    out_ready = 0;
    run(2, 0, 0, base);
    for (int i = 1; i <= 6; i++) begin
      @(posedge adc_clk);
      #1;
      if (i == 2) chk("t6 valid", out_valid, 1);
      if (i == 4) chk("t6 overrun", overrun, 1);
    end
    #1 rst = 1;
    #1;
    chk("t6 rst valid", out_valid, 0);
    chk("t6 rst busy", busy, 0);
    chk("t6 rst overrun", overrun, 0);
    chk("t6 rst data", out_data, 0);
    #1 rst = 0;
    out_ready = 1;
    nv = 0;
    repeat (10) begin
      @(posedge adc_clk);
      #1;
      if (out_valid || busy) nv++;
    end
    chk("t6 no tick after rst", nv, 0);
    chk("queue drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
